// File: rtl/inst_enc_pkg.sv
// Shared types and constants for the MIPS instruction encoder.
// Format codes, field widths/positions and the loader state enum.
// Imported by the interface, the packer and the top.
package inst_enc_pkg;

    typedef enum logic [1:0] {
        FMT_R   = 2'b00,
        FMT_I   = 2'b01,
        FMT_J   = 2'b10,
        FMT_RSV = 2'b11
    } fmt_e;

    localparam int INST_W  = 32;
    localparam int OP_W    = 6;
    localparam int REG_W   = 5;
    localparam int SHAMT_W = 5;
    localparam int IMM_W   = 16;
    localparam int ADDR_W  = 26;
    localparam int FUNCT_W = 6;

    localparam int OP_MSB    = 31;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;

    typedef enum logic {
        LOAD = 1'b0,
        DONE = 1'b1
    } state_e;

endpackage

// File: rtl/inst_encoder_if.sv
// Field-set input stream and encoded-word output stream of the encoder.
// slave: the encoder side; master: loader / instruction-memory side.
// Both streams use valid/ready handshakes.
interface inst_encoder_if;
    import inst_enc_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           fmt;
    logic [OP_W-1:0]      op;
    logic [REG_W-1:0]     rs;
    logic [REG_W-1:0]     rt;
    logic [REG_W-1:0]     rd;
    logic [SHAMT_W-1:0]   shamt;
    logic [IMM_W-1:0]     imm;
    logic [ADDR_W-1:0]    addr;
    logic [FUNCT_W-1:0]   funct;

    logic                 out_valid;
    logic                 out_ready;
    logic [INST_W-1:0]    out_inst;
    logic [31:0]          out_addr;
    logic                 out_last;

    modport slave (
        input  in_valid, fmt, op, rs, rt, rd, shamt, imm, addr, funct, out_ready,
        output in_ready, out_valid, out_inst, out_addr, out_last
    );

    modport master (
        output in_valid, fmt, op, rs, rt, rd, shamt, imm, addr, funct, out_ready,
        input  in_ready, out_valid, out_inst, out_addr, out_last
    );

endinterface

// File: rtl/inst_pack.sv
// Purpose: pack decoded fields into an R, I or J format instruction word.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module inst_pack
    import inst_enc_pkg::*;
(
    input  logic [1:0]          fmt,
    input  logic [OP_W-1:0]     op,
    input  logic [REG_W-1:0]    rs,
    input  logic [REG_W-1:0]    rt,
    input  logic [REG_W-1:0]    rd,
    input  logic [SHAMT_W-1:0]  shamt,
    input  logic [IMM_W-1:0]    imm,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [INST_W-1:0]   inst
);

    // Opcode is common to all formats; the rest depends on the format.
    // The reserved code falls through to R so it is harmless if emitted.
    always_comb begin
        inst = '0;
        inst[OP_MSB -: OP_W] = op;
        case (fmt)
            FMT_I: begin
                inst[RS_LSB +: REG_W] = rs;
                inst[RT_LSB +: REG_W] = rt;
                inst[IMM_W-1:0]       = imm;
            end
            FMT_J: begin
                inst[ADDR_W-1:0] = addr;
            end
            default: begin
                inst[RS_LSB +: REG_W]        = rs;
                inst[RT_LSB +: REG_W]        = rt;
                inst[RD_LSB +: REG_W]        = rd;
                inst[SHAMT_LSB +: SHAMT_W]   = shamt;
                inst[FUNCT_W-1:0]            = funct;
            end
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Purpose: encode field sets into instruction words with sequential addresses; stops after DEPTH words (INST_ENC_CHECK_EN adds reserved-format drop + err).
// Latency: one cycle, accept in N -> out_valid in N+1, one word per cycle.
// Backpressure: in_ready drops while the held word is stalled by out_ready, and after the last word until restart.
module inst_encoder
    import inst_enc_pkg::*;
#(
    parameter int          DEPTH   = 64,
    parameter logic [31:0] PC_BASE = 32'h0000_0000
)(
    input  logic            clk,
    input  logic            rst,
    input  logic            restart,
    inst_encoder_if.slave   bus,
    output logic            done,
    output logic            err
);

    localparam int                IDX_W    = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

    state_e              state;
    logic [IDX_W-1:0]    index;
    logic                full;      // last word already accepted; no wrap
    logic [INST_W-1:0]   packed_inst;
    logic [31:0]         cur_addr;
    logic                slot_free;
    logic                accept;
    logic                rsv;
    logic                emit;
    logic                out_hs;

    logic                out_valid_q;
    logic [INST_W-1:0]   out_inst_q;
    logic [31:0]         out_addr_q;
    logic                out_last_q;

    inst_pack u_pack (
        .fmt   (bus.fmt),
        .op    (bus.op),
        .rs    (bus.rs),
        .rt    (bus.rt),
        .rd    (bus.rd),
        .shamt (bus.shamt),
        .imm   (bus.imm),
        .addr  (bus.addr),
        .funct (bus.funct),
        .inst  (packed_inst)
    );

    // full also covers a stalled last word, so no separate index test is needed.
    assign slot_free    = !out_valid_q || bus.out_ready;
    assign bus.in_ready = (state == LOAD) && !restart && !full && slot_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign emit         = accept && !rsv;
    assign out_hs       = out_valid_q && bus.out_ready;
    assign cur_addr     = PC_BASE + (32'(index) << 2);

`ifdef INST_ENC_CHECK_EN
    assign rsv = (bus.fmt == FMT_RSV);
`else
    assign rsv = 1'b0;
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_inst  = out_inst_q;
    assign bus.out_addr  = out_addr_q;
    assign bus.out_last  = out_last_q;

    // Output register: load on emit, drain on handshake, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_inst_q  <= '0;
            out_addr_q  <= PC_BASE;
            out_last_q  <= 1'b0;
        end else if (emit) begin
            out_valid_q <= 1'b1;
            out_inst_q  <= packed_inst;
            out_addr_q  <= cur_addr;
            out_last_q  <= (index == LAST_IDX);
        end else if (out_hs) begin
            out_valid_q <= 1'b0;
        end
    end

    // Word index: saturates at the last word and flags full instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            index <= '0;
            full  <= 1'b0;
        end else if (restart) begin
            index <= '0;
            full  <= 1'b0;
        end else if (emit) begin
            if (index == LAST_IDX) begin
                full <= 1'b1;
            end else begin
                index <= index + 1'b1;
            end
        end
    end

    // Loader FSM: DONE once the last word leaves; restart wins over a same-cycle handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            done  <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (!restart && full && out_hs && out_last_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (restart) begin
                        state <= LOAD;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= LOAD;
                    done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef INST_ENC_CHECK_EN
    // Sticky flag for consumed reserved-format field sets.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (restart) begin
            err <= 1'b0;
        end else if (accept && rsv) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: scoreboard queue filled on acceptance,
// drained by an output monitor, with a field-arithmetic reference model.
// Directed test-plan scenarios followed by a randomized phase.
module tb_inst_encoder;
    import inst_enc_pkg::*;

    localparam int          DEPTH   = 4;
    localparam logic [31:0] PC_BASE = 32'h0040_0000;

    logic clk = 1'b0;
    logic rst;
    logic restart;
    logic done;
    logic err;

    inst_encoder_if bus();

    inst_encoder #(.DEPTH(DEPTH), .PC_BASE(PC_BASE)) dut (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .bus     (bus),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] addr;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state (stream level)
    int   n_acc  = 0;
    bit   full_m = 0;
    bit   done_m = 0;
    bit   err_m  = 0;
    bit   exp_ov = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_inst(input logic [1:0] f, input logic [5:0] op,
                                               input logic [4:0] rs, input logic [4:0] rt,
                                               input logic [4:0] rd, input logic [4:0] sh,
                                               input logic [15:0] imm, input logic [25:0] ad,
                                               input logic [5:0] fn);
        longint unsigned w;
        w = longint'(op) * 64'd67108864;
        if (f == 2'b01)
            w = w + longint'(rs) * 64'd2097152 + longint'(rt) * 64'd65536 + longint'(imm);
        else if (f == 2'b10)
            w = w + longint'(ad);
        else
            w = w + longint'(rs) * 64'd2097152 + longint'(rt) * 64'd65536
                  + longint'(rd) * 64'd2048 + longint'(sh) * 64'd64 + longint'(fn);
        return w[31:0];
    endfunction

    // Input side: check in_ready against the model, push expected word on acceptance.
    always @(negedge clk) begin
        bit   er;
        bit   drop;
        exp_t e;
        if (!rst) begin
            er = !restart && !full_m && (!exp_ov || bus.out_ready);
            chk("in_ready", 32'(bus.in_ready), 32'(er));
            if (bus.in_valid && bus.in_ready) begin
                drop = 0;
`ifdef INST_ENC_CHECK_EN
                drop = (bus.fmt == 2'b11);
`endif
                if (drop) begin
                    err_m = 1;
                end else begin
                    e.inst = model_inst(bus.fmt, bus.op, bus.rs, bus.rt, bus.rd, bus.shamt,
                                        bus.imm, bus.addr, bus.funct);
                    e.addr = PC_BASE + 32'(4 * n_acc);
                    e.last = (n_acc == DEPTH - 1);
                    q.push_back(e);
                    n_acc++;
                    if (n_acc == DEPTH) full_m = 1;
                end
            end
            if (restart) begin
                n_acc  = 0;
                full_m = 0;
                done_m = 0;
                err_m  = 0;
            end
        end
    end

    // Output side: compare presented word with the queue head, pop on handshake.
    initial begin
        forever begin
            @(posedge clk);
            #4;
            if (!rst) begin
                exp_ov = (q.size() != 0);
                chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
                chk("done", 32'(done), 32'(done_m));
                chk("err", 32'(err), 32'(err_m));
                if (bus.out_valid && exp_ov) begin
                    chk("out_inst", bus.out_inst, q[0].inst);
                    chk("out_addr", bus.out_addr, q[0].addr);
                    chk("out_last", 32'(bus.out_last), 32'(q[0].last));
                    if (bus.out_ready) begin
                        if (q[0].last && full_m) done_m = 1;
                        void'(q.pop_front());
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] f, input logic [5:0] op, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd, input logic [4:0] sh,
                         input logic [15:0] imm, input logic [25:0] ad, input logic [5:0] fn);
        bus.fmt   = f;
        bus.op    = op;
        bus.rs    = rs;
        bus.rt    = rt;
        bus.rd    = rd;
        bus.shamt = sh;
        bus.imm   = imm;
        bus.addr  = ad;
        bus.funct = fn;
        bus.in_valid = 1'b1;
    endtask

    task automatic drive_rand(input logic [1:0] f);
        drive(f, 6'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
              16'($urandom), 26'($urandom), 6'($urandom));
    endtask

    task automatic do_restart();
        restart = 1'b1;
        step();
        restart = 1'b0;
    endtask

    task automatic model_reset();
        q.delete();
        n_acc  = 0;
        full_m = 0;
        done_m = 0;
        err_m  = 0;
        exp_ov = 0;
    endtask

    initial begin
        rst = 1'b1;
        restart = 1'b0;
        bus.out_ready = 1'b1;
        drive(2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_inst", bus.out_inst, 32'd0);
        chk("rst_out_addr", bus.out_addr, PC_BASE);
        chk("rst_out_last", 32'(bus.out_last), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        rst = 1'b0;

        // R type
        drive(2'b00, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 6'h20);
        step();
        bus.in_valid = 1'b0;
        #3;
        chk("r_valid", 32'(bus.out_valid), 32'd1);
        chk("r_inst", bus.out_inst, 32'h0022_1820);
        chk("r_addr", bus.out_addr, PC_BASE);
        step();

        // I then J back to back
        do_restart();
        drive(2'b01, 6'h08, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFC, 26'h0, 6'h0);
        step();
        drive(2'b10, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h000_0010, 6'h0);
        #3;
        chk("i_inst", bus.out_inst, 32'h2022_FFFC);
        chk("i_addr", bus.out_addr, PC_BASE);
        step();
        bus.in_valid = 1'b0;
        #3;
        chk("j_inst", bus.out_inst, 32'h0800_0010);
        chk("j_addr", bus.out_addr, PC_BASE + 32'd4);
        step();

        // Backpressure
        do_restart();
        drive_rand(2'b00);
        step();
        bus.out_ready = 1'b0;
        drive_rand(2'b01);
        for (int i = 0; i < 3; i++) begin
            #3;
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_addr", bus.out_addr, PC_BASE);
            step();
        end
        bus.out_ready = 1'b1;
        #3;
        chk("bp_release_ready", 32'(bus.in_ready), 32'd1);
        step();
        bus.in_valid = 1'b0;
        #3;
        chk("bp_next_addr", bus.out_addr, PC_BASE + 32'd4);
        step();

        // Fill to DEPTH
        do_restart();
        for (int i = 0; i < DEPTH; i++) begin
            drive_rand(2'($urandom_range(0, 2)));
            step();
        end
        drive_rand(2'b00);
        #3;
        chk("fill_last", 32'(bus.out_last), 32'd1);
        chk("fill_last_addr", bus.out_addr, PC_BASE + 32'd12);
        chk("fill_5th_ready", 32'(bus.in_ready), 32'd0);
        step();
        #3;
        chk("fill_done", 32'(done), 32'd1);
        chk("fill_done_ready", 32'(bus.in_ready), 32'd0);
        step();
        do_restart();
        step();
        bus.in_valid = 1'b0;
        #3;
        chk("restart_addr", bus.out_addr, PC_BASE);
        chk("restart_done", 32'(done), 32'd0);
        step();

        // Reset mid-stream
        bus.out_ready = 1'b0;
        drive_rand(2'b01);
        step();
        bus.in_valid = 1'b0;
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_addr", bus.out_addr, PC_BASE);
        model_reset();
        step();
        step();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive_rand(2'b10);
        step();
        bus.in_valid = 1'b0;
        #3;
        chk("post_rst_addr", bus.out_addr, PC_BASE);
        step();

`ifdef INST_ENC_CHECK_EN
        // Reserved format is consumed and flagged
        do_restart();
        drive_rand(2'b11);
        step();
        drive_rand(2'b00);
        #3;
        chk("rsv_no_valid", 32'(bus.out_valid), 32'd0);
        chk("rsv_err", 32'(err), 32'd1);
        step();
        bus.in_valid = 1'b0;
        #3;
        chk("rsv_next_addr", bus.out_addr, PC_BASE);
        chk("rsv_err_sticky", 32'(err), 32'd1);
        step();
`endif

        // Randomized phase
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 1) == 1) drive_rand(2'($urandom_range(0, 3)));
            else bus.in_valid = 1'b0;
            bus.out_ready = ($urandom_range(0, 3) != 0);
            restart       = ($urandom_range(0, 24) == 0);
            step();
        end
        restart = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) step();
        chk("drain_empty", 32'(q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
